// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32x32 multiply/divide unit that owns the HI/LO
// register pair. MULT/MULTU use 32 shift-add steps and DIV/DIVU use 32
// restoring-division steps. The sign correction and the HI/LO write happen
// together in one final cycle.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0. While busy=1, start is ignored and nothing is queued. done pulses
// for exactly one cycle, and that is the cycle in which HI/LO first show the
// new mul/div result.
module hilo_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;         // |multiplicand| or |dividend|
  logic [31:0] b_q, b_d;         // |multiplier| or |divisor|
  logic [63:0] acc_q, acc_d;     // product, or {remainder, quotient}
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d;  // negate product / quotient
  logic        neg_hi_q, neg_hi_d;  // negate remainder
  logic        dz_q, dz_d;          // divide by zero
  logic [31:0] xr_q, xr_d;          // raw dividend, becomes HI on divide by zero
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Scratch values for the datapath
  logic        is_signed;
  logic [31:0] abs_x, abs_y;
  logic [32:0] sum33;
  logic [32:0] rem33;
  logic [32:0] diff33;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      xr_q     <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      xr_q     <= xr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic, iteration steps and the final HI/LO write
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    xr_d     = xr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    is_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
    abs_x     = (is_signed && x[31]) ? (32'd0 - x) : x;
    abs_y     = (is_signed && y[31]) ? (32'd0 - y) : y;

    // Multiply step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the pair right by one.
    sum33  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? a_q : 32'd0)};
    // Restoring step: the shifted partial remainder needs 33 bits because
    // it can exceed the divisor by up to a factor of two.
    rem33  = acc_q[63:31];
    diff33 = rem33 - {1'b0, b_q};

    prod_fix = neg_lo_q ? (64'd0 - acc_q) : acc_q;
    quo_fix  = neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (md_op)
            OP_MULTU, OP_MULT: begin
              a_d      = abs_x;
              b_d      = abs_y;
              acc_d    = {32'd0, abs_y};
              is_div_d = 1'b0;
              neg_lo_d = is_signed && (x[31] ^ y[31]);
              neg_hi_d = 1'b0;
              dz_d     = 1'b0;
              xr_d     = x;
              cnt_d    = 5'd0;
              state_d  = S_MUL;
            end
            OP_DIVU, OP_DIV: begin
              a_d      = abs_x;
              b_d      = abs_y;
              acc_d    = {32'd0, abs_x};
              is_div_d = 1'b1;
              neg_lo_d = is_signed && (x[31] ^ y[31]);
              neg_hi_d = is_signed && x[31];
              dz_d     = (y == 32'd0);
              xr_d     = x;
              cnt_d    = 5'd0;
              state_d  = S_DIV;
            end
            OP_MTHI: hi_d = x;
            OP_MTLO: lo_d = x;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {sum33, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIN;
      end
      S_DIV: begin
        if (!diff33[32]) acc_d = {diff33[31:0], acc_q[30:0], 1'b1};
        else             acc_d = {acc_q[62:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIN;
      end
      S_FIN: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (dz_q) begin
          hi_d = xr_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_FIN);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed testbench for hilo_muldiv. Inputs are driven on the falling
// clock edge and outputs are sampled on the falling edge, away from the
// rising edge where the DUT updates.
module tb_hilo_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;
  int done_cnt;

  hilo_muldiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .md_op (md_op),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses seen at falling edges
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Driver: present a request for one cycle. Returns at the falling edge
  // just after the accepting rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] xv, input logic [31:0] yv);
    start = 1'b1; md_op = op; x = xv; y = yv;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
  endtask

  // Driver: wait out an operation that has just been accepted. Reports the
  // number of busy cycles, whether done is set once busy drops, and whether
  // HI/LO moved while busy.
  task automatic wait_op(output int busy_cycles, output logic done_seen, output logic held);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    busy_cycles = 0;
    held = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b1) break;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      busy_cycles++;
      @(negedge clk);
    end
    done_seen = done;
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (hi !== 32'd0)   begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'd0)   begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu();
    int bc; logic ds, hd;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_op(bc, ds, hd);
    total++; if (bc != 33)            begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
    total++; if (ds !== 1'b1)         begin bad++; $display("FAIL multu_done got=%0b exp=1", ds); end
    total++; if (hd !== 1'b1)         begin bad++; $display("FAIL multu_hold got=%0b exp=1", hd); end
    total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
    total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
    @(negedge clk);
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL multu_done_pulse got=%0b exp=0", done); end
  endtask

  task automatic test_mult();
    int bc; logic ds, hd;
    issue(3'd2, 32'hFFFF_FFFD, 32'd7);
    wait_op(bc, ds, hd);
    total++; if (ds !== 1'b1)          begin bad++; $display("FAIL mult_done got=%0b exp=1", ds); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
    @(negedge clk);
  endtask

  task automatic test_div();
    int bc; logic ds, hd;
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    wait_op(bc, ds, hd);
    total++; if (bc != 33)             begin bad++; $display("FAIL div_busy_cycles got=%0d exp=33", bc); end
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    @(negedge clk);
    issue(3'd3, 32'd100, 32'd0);
    wait_op(bc, ds, hd);
    total++; if (ds !== 1'b1)          begin bad++; $display("FAIL divz_done got=%0b exp=1", ds); end
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_lo got=%h exp=ffffffff", lo); end
    total++; if (hi !== 32'd100)       begin bad++; $display("FAIL divz_hi got=%h exp=00000064", hi); end
    @(negedge clk);
    issue(3'd4, 32'hFFFF_FFF9, 32'd0);
    wait_op(bc, ds, hd);
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sdivz_lo got=%h exp=ffffffff", lo); end
    total++; if (hi !== 32'hFFFF_FFF9) begin bad++; $display("FAIL sdivz_hi got=%h exp=fffffff9", hi); end
    @(negedge clk);
  endtask

  task automatic test_busy_conflict();
    int bc; logic ds, hd;
    logic [31:0] h0;
    int dc0;
    issue(3'd3, 32'd10, 32'd3);
    h0 = hi;
    repeat (4) @(negedge clk);
    start = 1'b1; md_op = 3'd5; x = 32'h1234;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    total++; if (hi !== h0)    begin bad++; $display("FAIL conflict_hi_hold got=%h exp=%h", hi, h0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL conflict_busy got=%0b exp=1", busy); end
    wait_op(bc, ds, hd);
    total++; if (ds !== 1'b1)   begin bad++; $display("FAIL conflict_done got=%0b exp=1", ds); end
    total++; if (hi !== 32'd1)  begin bad++; $display("FAIL conflict_hi got=%h exp=00000001", hi); end
    total++; if (lo !== 32'd3)  begin bad++; $display("FAIL conflict_lo got=%h exp=00000003", lo); end
    @(negedge clk);
    dc0 = done_cnt;
    issue(3'd6, 32'hABCD, 32'd0);
    total++; if (lo !== 32'hABCD) begin bad++; $display("FAIL mtlo_lo got=%h exp=0000abcd", lo); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL mtlo_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL mtlo_done got=%0b exp=0", done); end
    total++; if (hi !== 32'd1)    begin bad++; $display("FAIL mtlo_hi_kept got=%h exp=00000001", hi); end
    issue(3'd7, 32'h5555, 32'd0);
    total++; if (lo !== 32'hABCD || busy !== 1'b0) begin bad++; $display("FAIL op7_noeffect got lo=%h busy=%0b exp lo=0000abcd busy=0", lo, busy); end
    total++; if (done_cnt != dc0) begin bad++; $display("FAIL mtlo_no_done got=%0d exp=%0d", done_cnt, dc0); end
  endtask

  task automatic test_reset_abort();
    int bc; logic ds, hd;
    int dc0;
    dc0 = done_cnt;
    issue(3'd1, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    total++; if (hi !== 32'd0)  begin bad++; $display("FAIL abort_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'd0)  begin bad++; $display("FAIL abort_lo got=%h exp=0", lo); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (done_cnt != dc0) begin bad++; $display("FAIL abort_no_done got=%0d exp=%0d", done_cnt, dc0); end
    issue(3'd1, 32'd5, 32'd6);
    wait_op(bc, ds, hd);
    total++; if (bc != 33)       begin bad++; $display("FAIL rerun_busy_cycles got=%0d exp=33", bc); end
    total++; if (lo !== 32'd30)  begin bad++; $display("FAIL rerun_lo got=%h exp=0000001e", lo); end
    total++; if (hi !== 32'd0)   begin bad++; $display("FAIL rerun_hi got=%h exp=0", hi); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int bc; logic ds, hd;
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_op(bc, ds, hd);
    total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL ovf_lo got=%h exp=80000000", lo); end
    total++; if (hi !== 32'd0)         begin bad++; $display("FAIL ovf_hi got=%h exp=0", hi); end
  endtask

  // Starts a new op in the first cycle with busy=0, directly after done
  task automatic test_back_to_back();
    int bc; logic ds, hd;
    issue(3'd3, 32'd100, 32'd7);
    wait_op(bc, ds, hd);
    total++; if (ds !== 1'b1)   begin bad++; $display("FAIL b2b_first_done got=%0b exp=1", ds); end
    total++; if (lo !== 32'd14) begin bad++; $display("FAIL b2b_first_lo got=%h exp=0000000e", lo); end
    total++; if (hi !== 32'd2)  begin bad++; $display("FAIL b2b_first_hi got=%h exp=00000002", hi); end
    issue(3'd2, 32'h0001_0000, 32'hFFFF_0000);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%0b exp=1", busy); end
    wait_op(bc, ds, hd);
    total++; if (bc != 33)             begin bad++; $display("FAIL b2b_busy_cycles got=%0d exp=33", bc); end
    total++; if (hd !== 1'b1)          begin bad++; $display("FAIL b2b_hold got=%0b exp=1", hd); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL b2b_hi got=%h exp=ffffffff", hi); end
    total++; if (lo !== 32'd0)         begin bad++; $display("FAIL b2b_lo got=%h exp=0", lo); end
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; md_op = 3'd0; x = 32'd0; y = 32'd0;
    #1;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_busy_conflict();
    test_reset_abort();
    test_overflow();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide unit with the architectural HI/LO register pair for the MIPS CPU datapath. It takes the MULT/MULTU/DIV/DIVU work off the single-cycle ALU path and executes each operation iteratively over 32 cycles. It owns HI and LO and handles MTHI/MTLO writes; HI and LO are always readable for MFHI/MFLO. The pipeline stalls on `busy` while an operation is in flight.

## Interface
- No parameters; the datapath width is fixed at 32.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request strobe; accepted only when `busy`=0.
- `md_op`  in  3  0 none, 1 MULTU, 2 MULT, 3 DIVU, 4 DIV, 5 MTHI, 6 MTLO, 7 none.
- `x`  in  32  rs operand: multiplicand / dividend / MTHI-MTLO write data.
- `y`  in  32  rt operand: multiplier / divisor.
- `busy`  out  1  operation in flight; the issuer stalls while high.
- `done`  out  1  one-cycle pulse in the cycle HI/LO first show a new mul/div result.
- `hi`  out  32  HI register (product upper half / remainder).
- `lo`  out  32  LO register (product lower half / quotient).

## Operation
- States: IDLE, MUL, DIV, FIN.
- IDLE, `start`=1:
  - `md_op`=1..4: latch `|x|`, `|y|` (the raw values for the unsigned ops), the result sign bits and the op type. Clear the 5-bit iteration counter and go to MUL or DIV.
  - `md_op`=5: HI<=x. `md_op`=6: LO<=x. Both stay in IDLE, with no `busy` and no `done`.
  - `md_op`=0 or 7: no effect.
- MUL: one shift-add step per cycle on a 64-bit accumulator. Go to FIN after 32 steps (counter 31 -> FIN).
- DIV: one restoring step per cycle on a 64-bit remainder/quotient register. Go to FIN after 32 steps.
- FIN: apply the sign fix, write HI/LO, assert `done`, return to IDLE.
- Signed rules:
  - MULT: negate the 64-bit product iff x[31]^y[31].
  - DIV: negate the quotient iff x[31]^y[31]; negate the remainder iff x[31].
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero, signed or unsigned: LO=0xFFFFFFFF, HI=x. No sign fix is applied and no exception is raised.
- While `busy`=1, `start` is ignored regardless of `md_op`, including MTHI/MTLO. Nothing is queued; the issuer must re-present the request.
- HI and LO hold their old values throughout an operation and change only in FIN or on an MTHI/MTLO write.

## Timing
- Reset (asynchronous on the falling edge of `rst_n`): state IDLE, counter 0, `busy`=0, `done`=0, `hi`=0, `lo`=0.
- Reset during MUL/DIV aborts the operation immediately. HI/LO are cleared and no `done` is produced.
- Mul/div accepted at edge E0:
  - `busy`=1 from E0 through the edge E33, which is the FIN edge (33 cycles high).
  - At E33: `busy` drops, `done`=1 for one cycle, and new `hi`/`lo` are visible. Latency is 33 cycles from acceptance.
- A new `start` can be accepted at E33+1, the first edge with `busy`=0, giving back-to-back throughput of one operation per 34 cycles.
- MTHI/MTLO: HI/LO are visible the cycle after the accepting edge.
- `busy`, `done`, `hi` and `lo` are all registered outputs, with no combinational path from the inputs.

## Test plan
- MULTU x=0xFFFFFFFF, y=0xFFFFFFFF:
  - `busy` is high 33 cycles.
  - Then `done` pulses with hi=0xFFFFFFFE, lo=0x00000001.
- MULT x=0xFFFFFFFD (-3), y=7: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV x=0xFFFFFFF9 (-7), y=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU x=100, y=0: lo=0xFFFFFFFF, hi=100.
- Busy conflicts:
  - Start DIVU 10/3; at cycle 5 pulse `start` with MTHI x=0x1234. The MTHI is ignored; at completion hi=1, lo=3.
  - Then MTLO x=0xABCD in IDLE: lo=0xABCD on the next cycle, with no `busy` and no `done`.
- Reset: start MULTU 5*6 and pull `rst_n` low at cycle 10.
  - `busy`, `hi` and `lo` go to 0 asynchronously and `done` never pulses.
  - After release, MULTU 5*6 completes with lo=30, hi=0.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
